// File: rtl/ws2812_apb_pkg.sv
// rtl/ws2812_apb_pkg.sv - shared types and constants for the WS2812 APB register path
//
// Purpose: requester FSM state encoding, WS2812 register offsets and
//          default bus widths shared by the APB requester and its users.
// Ports:   none (package).

package ws2812_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam logic [7:0] WS2812_CTRL_OFFSET = 8'h00;
    localparam logic [7:0] WS2812_DATA_OFFSET = 8'h04;

    localparam int DEFAULT_ADDR_W = 6;
    localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - single-outstanding APB requester with completer watchdog
//
// Purpose: accepts one command at a time, runs the APB setup/access phases,
//          and returns read data plus error/timeout status. A watchdog aborts
//          an ACCESS phase that lasts TIMEOUT cycles (TIMEOUT = 0 disables it).
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i                   command fields
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                 response fields
//   apb_psel_o, apb_penable_o,
//   apb_pwrite_o, apb_paddr_o,
//   apb_pwdata_o                  APB request (all registered)
//   apb_prdata_i, apb_pready_i,
//   apb_pslverr_i                 APB completion

module apb_requester
    import ws2812_apb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,

    output logic              apb_psel_o,
    output logic              apb_penable_o,
    output logic              apb_pwrite_o,
    output logic [ADDR_W-1:0] apb_paddr_o,
    output logic [DATA_W-1:0] apb_pwdata_o,
    input  logic [DATA_W-1:0] apb_prdata_i,
    input  logic              apb_pready_i,
    input  logic              apb_pslverr_i
);

    // A zero-width counter is illegal, so the disabled watchdog keeps one idle bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    apb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cmd_ready_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic              rsp_timeout_d;
    logic              psel_d;
    logic              penable_d;
    logic              pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_o;
        rsp_valid_d   = rsp_valid_o;
        rsp_rdata_d   = rsp_rdata_o;
        rsp_err_d     = rsp_err_o;
        rsp_timeout_d = rsp_timeout_o;
        psel_d        = apb_psel_o;
        penable_d     = apb_penable_o;
        pwrite_d      = apb_pwrite_o;
        paddr_d       = apb_paddr_o;
        pwdata_d      = apb_pwdata_o;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    // The APB request registers double as the command latch.
                    pwrite_d    = cmd_write_i;
                    paddr_d     = cmd_addr_i;
                    pwdata_d    = cmd_wdata_i;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                // PREADY is checked first so a completion on the expiry cycle wins.
                if (apb_pready_i) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_err_d     = apb_pslverr_i;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = apb_pwrite_o ? '0 : apb_prdata_i;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_valid_o && rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
            apb_pwrite_o  <= 1'b0;
            apb_paddr_o   <= '0;
            apb_pwdata_o  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_o   <= cmd_ready_d;
            rsp_valid_o   <= rsp_valid_d;
            rsp_rdata_o   <= rsp_rdata_d;
            rsp_err_o     <= rsp_err_d;
            rsp_timeout_o <= rsp_timeout_d;
            apb_psel_o    <= psel_d;
            apb_penable_o <= penable_d;
            apb_pwrite_o  <= pwrite_d;
            apb_paddr_o   <= paddr_d;
            apb_pwdata_o  <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - directed scoreboard bench for apb_requester

module tb_apb_requester;
    import ws2812_apb_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic          timeout;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    apb_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .apb_psel_o    (psel),
        .apb_penable_o (penable),
        .apb_pwrite_o  (pwrite),
        .apb_paddr_o   (paddr),
        .apb_pwdata_o  (pwdata),
        .apb_prdata_i  (prdata),
        .apb_pready_i  (pready),
        .apb_pslverr_i (pslverr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        rsp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            check({tag, "_err"}, 64'(rsp_err), 64'(e.err));
            check({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.timeout));
        end
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            step();
            n++;
        end
        check({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
        if (rsp_valid) check_rsp(tag);
    endtask

    // Present a command for one cycle; on return the accepting edge has passed.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [DW-1:0] held;

        // Reset state
        step();
        step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err | rsp_timeout), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        rst = 1'b0;
        step();

        // 1: zero-wait read of the control register
        pready = 1'b1;
        prdata = 32'hADD00000;
        exp_q.push_back('{rdata: 32'hADD00000, err: 1'b0, timeout: 1'b0});
        send(1'b0, AW'(WS2812_CTRL_OFFSET), '0);
        check("t1_setup_psel", 64'(psel), 64'd1);
        check("t1_setup_penable", 64'(penable), 64'd0);
        check("t1_setup_cmd_ready", 64'(cmd_ready), 64'd0);
        step();
        check("t1_access_psel", 64'(psel), 64'd1);
        check("t1_access_penable", 64'(penable), 64'd1);
        check("t1_access_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_rsp_psel", 64'(psel), 64'd0);
        check_rsp("t1");
        step();
        check("t1_after_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t1_after_cmd_ready", 64'(cmd_ready), 64'd1);

        // 2: write of the data register with three wait states
        pready = 1'b0;
        prdata = 32'hDEADBEEF;
        exp_q.push_back('{rdata: '0, err: 1'b0, timeout: 1'b0});
        send(1'b1, AW'(WS2812_DATA_OFFSET), 32'h00FF00AA);
        step();
        for (int i = 0; i < 4; i++) begin
            check("t2_penable", 64'(penable), 64'd1);
            check("t2_paddr", 64'(paddr), 64'h04);
            check("t2_pwdata", 64'(pwdata), 64'h00FF00AA);
            check("t2_pwrite", 64'(pwrite), 64'd1);
            check("t2_no_rsp", 64'(rsp_valid), 64'd0);
            if (i == 3) pready = 1'b1;
            step();
        end
        pready = 1'b0;
        check("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        check_rsp("t2");
        step();

        // 3: read completing with PSLVERR
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h12345678;
        exp_q.push_back('{rdata: 32'h12345678, err: 1'b1, timeout: 1'b0});
        send(1'b0, 6'h08, '0);
        wait_rsp("t3", 10);
        pready  = 1'b0;
        pslverr = 1'b0;
        step();

        // 4: completer never ready, watchdog aborts after TIMEOUT access cycles
        prdata = 32'hFFFFFFFF;
        exp_q.push_back('{rdata: '0, err: 1'b1, timeout: 1'b1});
        send(1'b0, 6'h0C, '0);
        step();
        cyc = 0;
        while (penable && cyc < 40) begin
            cyc++;
            step();
        end
        check("t4_access_cycles", 64'(cyc), 64'(TO));
        check("t4_psel_low", 64'(psel), 64'd0);
        check("t4_rsp_valid", 64'(rsp_valid), 64'd1);
        if (rsp_valid) check_rsp("t4");
        step();

        // 5: response back-pressure with a second command waiting
        rsp_ready = 1'b0;
        pready    = 1'b1;
        prdata    = 32'hCAFEF00D;
        exp_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, timeout: 1'b0});
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 6'h10;
        step();
        cmd_write = 1'b1;
        cmd_addr  = 6'h14;
        cmd_wdata = 32'h5A5A5A5A;
        exp_q.push_back('{rdata: '0, err: 1'b0, timeout: 1'b0});
        step();
        step();
        check("t5_rsp_valid", 64'(rsp_valid), 64'd1);
        held = rsp_rdata;
        check_rsp("t5a");
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", 64'(rsp_valid), 64'd1);
            check("t5_hold_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
            check("t5_hold_cmd_ready", 64'(cmd_ready), 64'd0);
            check("t5_hold_psel", 64'(psel), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("t5_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_hs_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t5_hs_psel", 64'(psel), 64'd0);
        step();
        cmd_valid = 1'b0;
        check("t5_next_psel", 64'(psel), 64'd1);
        check("t5_next_cmd_ready", 64'(cmd_ready), 64'd0);
        check("t5_next_paddr", 64'(paddr), 64'h14);
        check("t5_next_pwrite", 64'(pwrite), 64'd1);
        wait_rsp("t5b", 10);
        pready = 1'b0;
        step();

        // 6: reset pulse during ACCESS discards the transfer
        send(1'b0, 6'h20, '0);
        step();
        check("t6_in_access", 64'(penable), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_psel", 64'(psel), 64'd0);
        check("t6_async_penable", 64'(penable), 64'd0);
        check("t6_async_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t6_async_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        rst    = 1'b0;
        pready = 1'b1;
        cyc    = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid || psel) cyc++;
            step();
        end
        check("t6_no_activity", 64'(cyc), 64'd0);
        check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
